// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - request/result bundle for the sequential divider
interface div_seq_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_by_zero
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - restoring shift-subtract divider, one quotient bit per clock
module div_seq_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    div_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dbz_q, dbz_d;

    // {rem,quo} shifted left by one; the remainder keeps N+1 bits so the trial
    // subtraction's sign lands in its MSB
    logic [2*N:0]  shifted;
    logic [N:0]    trial;

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;

    // next-state: operand capture, one restoring step per CALC cycle, result load
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        shifted = {rem_q, quo_q} << 1;
        trial   = shifted[2*N:N] - {1'b0, b_q};
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    quo_d = bus.a;
                    b_d   = bus.b;
                    rem_d = '0;
                    cnt_d = CW'(N);
                    if (bus.b != '0) begin
                        state_d = CALC;
                    end else begin
                        // zero divisor: skip iteration, report all-ones quotient
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = bus.a;
                        dbz_d   = 1'b1;
                    end
                end
            end
            CALC: begin
                if (!trial[N]) begin
                    rem_d = trial;
                    quo_d = {shifted[N-1:1], 1'b1};
                end else begin
                    rem_d = shifted[2*N:N];
                    quo_d = shifted[N-1:0];
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    q_d     = quo_d;
                    r_d     = rem_d[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - directed and swept checks of the sequential divider
module tb_div_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    div_seq_ctrl_if #(.N(8))  bus8 ();
    div_seq_ctrl_if #(.N(16)) bus16 ();

    div_seq_ctrl #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    div_seq_ctrl #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ed, output int dc);
        int lat;
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        tick();
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            check("busy_during_op", bus8.busy, 1);
            tick();
            lat++;
        end
        dc = cyc;
        check("latency8", lat, ed ? 0 : 8);
        check("q8", bus8.q, eq);
        check("r8", bus8.r, er);
        check("dbz8", bus8.div_by_zero, ed);
        check("busy_in_done", bus8.busy, 1);
        tick();
        check("done_one_cycle", bus8.done, 0);
        check("busy_back_idle", bus8.busy, 0);
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv);
        int lat;
        bus16.start = 1'b1;
        bus16.a     = av;
        bus16.b     = bv;
        tick();
        bus16.start = 1'b0;
        lat = 0;
        while (bus16.done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        check("latency16", lat, 16);
        check("q16", bus16.q, av / bv);
        check("r16", bus16.r, av % bv);
        check("dbz16", bus16.div_by_zero, 0);
        tick();
    endtask

    initial begin
        int c1, c2, lat;
        logic saw_done;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1};
        vecs[2]  = '{8'd180, 8'd11,  8'd16,  8'd4,   1'b0};
        vecs[3]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[4]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[5]  = '{8'd9,   8'd9,   8'd1,   8'd0,   1'b0};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[8]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
        vecs[9]  = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
        vecs[10] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
        vecs[11] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};

        tick();
        tick();
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_q", bus8.q, 0);
        check("rst_r", bus8.r, 0);
        check("rst_dbz", bus8.div_by_zero, 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_start_busy", bus8.busy, 0);

        for (int i = 0; i < 12; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, c1);
        end

        // back-to-back: second start on the first IDLE edge
        run8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, c1);
        run8(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, c2);
        check("b2b_spacing", c2 - c1, 10);

        // start re-pulsed during CALC and in the DONE cycle is ignored
        bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd3;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd9;
        tick();
        bus8.start = 1'b0;
        lat = 3;
        while (bus8.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("ign_latency", lat, 8);
        check("ign_q", bus8.q, 66);
        check("ign_r", bus8.r, 2);
        bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd9;
        tick();
        bus8.start = 1'b0;
        check("ign_done_start_busy", bus8.busy, 0);
        check("ign_done_start_done", bus8.done, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", bus8.q, 66);
            check("hold_r", bus8.r, 2);
            check("hold_busy", bus8.busy, 0);
        end

        // reset asserted for one edge mid-CALC aborts without a done pulse
        bus8.start = 1'b1; bus8.a = 8'd180; bus8.b = 8'd11;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", bus8.busy, 0);
        check("abort_done", bus8.done, 0);
        check("abort_q", bus8.q, 0);
        check("abort_r", bus8.r, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        run8(8'd180, 8'd11, 8'd16, 8'd4, 1'b0, c1);

        // N=16 sweep
        run16(16'hFFFF, 16'd1);
        run16(16'd0, 16'hFFFF);
        run16(16'hFFFF, 16'hFFFF);
        run16(16'd1234, 16'd1235);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            run16(ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
